// File: rtl/fifo_arbiter_if.sv
// Signal bundle between the two producers, the consumer and the downstream FIFO.
// The arbiter sits on the slave side; the environment drives the master side.
interface fifo_arbiter_if #(
    parameter int M = 2
);
    logic         req0;
    logic         req1;
    logic [M-1:0] data0;
    logic [M-1:0] data1;
    logic         ack0;
    logic         ack1;
    logic         rd_req;
    logic         rd_valid;
    logic         fifo_push;
    logic         fifo_pop;
    logic [M-1:0] fifo_in;
    logic         fifo_full;
    logic         full;
    logic         empty;
    logic         err;

    modport master (
        output req0, req1, data0, data1, rd_req, fifo_full,
        input  ack0, ack1, rd_valid, fifo_push, fifo_pop, fifo_in, full, empty, err
    );

    modport slave (
        input  req0, req1, data0, data1, rd_req, fifo_full,
        output ack0, ack1, rd_valid, fifo_push, fifo_pop, fifo_in, full, empty, err
    );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter feeding two producers into one FIFO, with a shadow
// occupancy count, registered FIFO strobes and a sticky full-flag cross-check.
module fifo_arbiter #(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic           clk,
    input  logic           reset,
    fifo_arbiter_if.slave  bus
);
    localparam int             CW      = $clog2(N + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(N);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          ptr;
    logic          chg_p0;
    logic          elig0;
    logic          elig1;
    logic          grant;
    logic          win;
    logic          pop_issue;

    // Eligibility looks only at the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        elig0     = 1'b0;
        elig1     = 1'b0;
        grant     = 1'b0;
        win       = 1'b0;
        pop_issue = 1'b0;
        cnt_next  = cnt;
        elig0     = bus.req0 && !bus.ack0 && (cnt < CNT_MAX);
        elig1     = bus.req1 && !bus.ack1 && (cnt < CNT_MAX);
        grant     = elig0 || elig1;
        win       = (elig0 && elig1) ? ~ptr : elig1;
        pop_issue = bus.rd_req && (cnt != '0);
        cnt_next  = cnt + CW'(grant) - CW'(pop_issue);
    end

    assign bus.full  = (cnt == CNT_MAX);
    assign bus.empty = (cnt == '0);

    // Stage p0: grant/pop decisions registered onto the strobes and count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            ptr           <= 1'b1;
            chg_p0        <= 1'b0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.fifo_push <= 1'b0;
            bus.fifo_pop  <= 1'b0;
            bus.fifo_in   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            chg_p0        <= grant ^ pop_issue;
            bus.ack0      <= grant && !win;
            bus.ack1      <= grant && win;
            bus.fifo_push <= grant;
            bus.fifo_pop  <= pop_issue;
            bus.rd_valid  <= bus.fifo_pop;
            if (grant) begin
                ptr         <= win;
                bus.fifo_in <= win ? bus.data1 : bus.data0;
            end
            // Compared one cycle after a count change, once the FIFO has seen the strobe.
            if (chg_p0 && (bus.fifo_full != (cnt == CNT_MAX))) begin
                bus.err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: single producer fill, full/empty corner
// cases, fifo_full mismatch, mid-operation reset and round-robin tie.
module tb_fifo_arbiter;
    logic clk;
    logic reset;
    logic force_full;
    int   tests;
    int   fails;

    fifo_arbiter_if #(.M(2)) bus();

    fifo_arbiter #(.N(4), .M(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream FIFO stand-in: its full flag tracks the arbiter unless forced.
    assign bus.fifo_full = force_full | bus.full;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        force_full = 1'b0;
        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.data0  = 2'b00;
        bus.data1  = 2'b00;
        bus.rd_req = 1'b0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        #2;
        check("rst_ack0",  32'(bus.ack0), 0);
        check("rst_ack1",  32'(bus.ack1), 0);
        check("rst_push",  32'(bus.fifo_push), 0);
        check("rst_pop",   32'(bus.fifo_pop), 0);
        check("rst_in",    32'(bus.fifo_in), 0);
        check("rst_rdv",   32'(bus.rd_valid), 0);
        check("rst_err",   32'(bus.err), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full",  32'(bus.full), 0);
        #9 reset = 1'b1;

        // Single producer: acks on alternate cycles until the count reaches 4.
        bus.req0  = 1'b1;
        bus.data0 = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("fill_ack0", 32'(bus.ack0), ((i % 2 == 0) && (i < 7)) ? 1 : 0);
            check("fill_push", 32'(bus.fifo_push), ((i % 2 == 0) && (i < 7)) ? 1 : 0);
            check("fill_cnt",  32'(dut.cnt), (i / 2 + 1 > 4) ? 4 : i / 2 + 1);
        end
        check("fill_in",   32'(bus.fifo_in), 1);
        check("fill_full", 32'(bus.full), 1);
        bus.req0 = 1'b0;

        // Full with a simultaneous pop: the pop must not open a slot that cycle.
        bus.req1   = 1'b1;
        bus.data1  = 2'b10;
        bus.rd_req = 1'b1;
        tick();
        check("fp_pop",  32'(bus.fifo_pop), 1);
        check("fp_ack1", 32'(bus.ack1), 0);
        check("fp_cnt",  32'(dut.cnt), 3);
        bus.rd_req = 1'b0;
        tick();
        check("fp_ack1b", 32'(bus.ack1), 1);
        check("fp_in",    32'(bus.fifo_in), 2);
        check("fp_rdv",   32'(bus.rd_valid), 1);
        check("fp_pop2",  32'(bus.fifo_pop), 0);
        check("fp_cnt2",  32'(dut.cnt), 4);
        bus.req1 = 1'b0;

        // Drain with back-to-back pops.
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dr_pop", 32'(bus.fifo_pop), 1);
            check("dr_cnt", 32'(dut.cnt), 3 - i);
        end
        tick();
        check("dr_pop_end", 32'(bus.fifo_pop), 0);
        check("dr_rdv_end", 32'(bus.rd_valid), 1);
        check("dr_empty",   32'(bus.empty), 1);
        bus.rd_req = 1'b0;

        // Empty with push and read together: push first, pop one cycle later.
        bus.req0   = 1'b1;
        bus.data0  = 2'b01;
        bus.rd_req = 1'b1;
        tick();
        check("ep_ack0", 32'(bus.ack0), 1);
        check("ep_push", 32'(bus.fifo_push), 1);
        check("ep_pop",  32'(bus.fifo_pop), 0);
        check("ep_cnt",  32'(dut.cnt), 1);
        bus.req0 = 1'b0;
        tick();
        check("ep_pop2", 32'(bus.fifo_pop), 1);
        check("ep_cnt2", 32'(dut.cnt), 0);
        bus.rd_req = 1'b0;
        tick();
        check("ep_rdv",   32'(bus.rd_valid), 1);
        check("ep_pop3",  32'(bus.fifo_pop), 0);
        check("ep_empty", 32'(bus.empty), 1);

        // fifo_full forced high while the count sits at 2.
        bus.req0  = 1'b1;
        bus.data0 = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        bus.req0   = 1'b0;
        force_full = 1'b1;
        check("mm_cnt",  32'(dut.cnt), 2);
        check("mm_err0", 32'(bus.err), 0);
        tick();
        check("mm_err1", 32'(bus.err), 1);
        force_full = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mm_sticky", 32'(bus.err), 1);

        // Reset while a push strobe is in flight at count 3.
        bus.req0  = 1'b1;
        bus.data0 = 2'b11;
        tick();
        check("mr_push_pre", 32'(bus.fifo_push), 1);
        check("mr_cnt_pre",  32'(dut.cnt), 3);
        bus.req1  = 1'b1;
        bus.data1 = 2'b01;
        #2 reset = 1'b0;
        #1;
        check("mr_ack0",  32'(bus.ack0), 0);
        check("mr_push",  32'(bus.fifo_push), 0);
        check("mr_in",    32'(bus.fifo_in), 0);
        check("mr_err",   32'(bus.err), 0);
        check("mr_cnt",   32'(dut.cnt), 0);
        check("mr_empty", 32'(bus.empty), 1);
        check("mr_full",  32'(bus.full), 0);
        #3 reset = 1'b1;

        // Both requesting from reset: grants alternate starting with req0.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("tie_ack0", 32'(bus.ack0), (i % 2 == 0) ? 1 : 0);
            check("tie_ack1", 32'(bus.ack1), (i % 2 == 1) ? 1 : 0);
            check("tie_in",   32'(bus.fifo_in), (i % 2 == 0) ? 3 : 1);
            check("tie_cnt",  32'(dut.cnt), i + 1);
        end
        tick();
        check("tie_ack0_full", 32'(bus.ack0), 0);
        check("tie_ack1_full", 32'(bus.ack1), 0);
        check("tie_push_full", 32'(bus.fifo_push), 0);
        check("tie_in_hold",   32'(bus.fifo_in), 1);
        check("tie_full",      32'(bus.full), 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
